// File: rtl/program_loader_if.sv
// Host/sequencer-facing signal bundle for program_loader.
//   slave  : the loader itself (takes host bytes and sequencer strobes, drives bus and status)
//   master : whoever drives the loader (host pins plus control sequencer, or a testbench)
interface program_loader_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] host_data;
   logic              host_valid;
   logic              host_ready;
   logic              ready;
   logic              read_ui_in;
   logic              done_load;
   logic              programming;
   logic [DATA_W-1:0] bus_out;
   logic              bus_oe;
   logic [4:0]        load_count;
   logic              prog_done;
   logic              underrun;
   logic              overflow;

   modport slave (
      input  start, host_data, host_valid, ready, read_ui_in, done_load,
      output host_ready, programming, bus_out, bus_oe, load_count,
             prog_done, underrun, overflow
   );

   modport master (
      output start, host_data, host_valid, ready, read_ui_in, done_load,
      input  host_ready, programming, bus_out, bus_oe, load_count,
             prog_done, underrun, overflow
   );
endinterface

// File: rtl/program_loader.sv
// program_loader: buffers host bytes and feeds them to the CPU control
// sequencer during programming mode, one byte per RAM-write instruction.
//
// Ports:
//   clk     system clock, everything updates on its rising edge
//   resetn  asynchronous active-low reset
//   pl      program_loader_if.slave:
//             start / host_data / host_valid / host_ready  host side
//             ready / read_ui_in / done_load / programming  sequencer side
//             bus_out / bus_oe                             CPU bus drive
//             load_count / prog_done / underrun / overflow status
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; host bytes ignored
// ARM    | prefilling buffer, waiting for sequencer T0 (ready)
// LOAD   | programming=1; bytes popped on read_ui_in, done_load counted
// DONE   | one cycle after the last write, then back to IDLE
//
// The buffer needs FIFO_DEPTH >= 2 and a power of two.
module program_loader #(
   parameter int WORDS      = 16,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            resetn,
   program_loader_if.slave pl
);
   localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
   localparam logic [4:0]  CNT_LAST = 5'(WORDS - 1);
   localparam logic [4:0]  CNT_FULL = 5'(WORDS);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_LOAD, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic [4:0]        load_count;
   logic              prog_done, underrun, overflow;
   logic              active, in_load, empty, full;
   logic              rd_req, pop, push, host_ready, flush;

   assign active  = (state == S_ARM) || (state == S_LOAD);
   assign in_load = (state == S_LOAD);
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign rd_req = in_load && pl.read_ui_in;
   assign pop    = rd_req && !empty;
   // A pop on the same edge frees a slot, so a full buffer can still take a byte.
   assign host_ready = active && (!full || pop);
   assign push       = pl.host_valid && host_ready;

   assign pl.host_ready  = host_ready;
   assign pl.programming = in_load;
   assign pl.bus_oe      = rd_req;
   assign pl.bus_out     = (in_load && !empty) ? mem[rd_ptr[AW-1:0]] : '0;
   assign pl.load_count  = load_count;
   assign pl.prog_done   = prog_done;
   assign pl.underrun    = underrun;
   assign pl.overflow    = overflow;

   always_comb begin
      state_nxt = state;
      flush     = 1'b0;
      case (state)
         S_IDLE: begin
            if (pl.start) begin
               state_nxt = S_ARM;
               flush     = 1'b1;
            end
         end
         S_ARM:  if (pl.ready) state_nxt = S_LOAD;
         S_LOAD: if (pl.done_load && (load_count == CNT_LAST)) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset: contents are only visible while the pointers say non-empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= pl.host_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         load_count <= '0;
         prog_done  <= 1'b0;
         underrun   <= 1'b0;
         overflow   <= 1'b0;
      end else if (flush) begin
         load_count <= '0;
         prog_done  <= 1'b0;
         underrun   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (in_load && pl.done_load && (load_count != CNT_FULL))
            load_count <= load_count + 5'd1;
         if (in_load && (state_nxt == S_DONE))
            prog_done <= 1'b1;
         if (rd_req && empty)
            underrun <= 1'b1;
         if (active && pl.host_valid && !host_ready)
            overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: a queue-based reference model tracks session
// mode, buffered bytes and sticky flags; a monitor pops expected bus bytes as
// the sequencer reads them and compares every DUT output each cycle.
// A second instance with WORDS=1 covers the single-word boundary.
module tb_program_loader;
   localparam int WORDS = 16;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   program_loader_if #(.DATA_W(8)) ifc ();
   program_loader_if #(.DATA_W(8)) ifc1 ();

   program_loader #(.WORDS(WORDS), .DATA_W(8), .FIFO_DEPTH(2)) u_dut (
      .clk(clk), .resetn(resetn), .pl(ifc.slave));
   program_loader #(.WORDS(1), .DATA_W(8), .FIFO_DEPTH(2)) u_dut1 (
      .clk(clk), .resetn(resetn), .pl(ifc1.slave));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_ARM, M_LOAD, M_DONE} mode_t;
   mode_t      mode     = M_IDLE;
   logic [7:0] sb[$];
   int         m_count  = 0;
   bit         m_done   = 0;
   bit         m_und    = 0;
   bit         m_ovf    = 0;
   bit         und_pend = 0;

   initial forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
         mode = M_IDLE; sb.delete(); m_count = 0;
         m_done = 0; m_und = 0; m_ovf = 0; und_pend = 0;
      end else begin
         if ((mode == M_ARM || mode == M_LOAD) && ifc.host_valid) begin
            if (sb.size() < 2) sb.push_back(ifc.host_data);
            else m_ovf = 1;
         end
         if (und_pend) m_und = 1;
         und_pend = 0;
         case (mode)
            M_IDLE: if (ifc.start) begin
               mode = M_ARM; sb.delete(); m_count = 0;
               m_done = 0; m_und = 0; m_ovf = 0;
            end
            M_ARM:  if (ifc.ready) mode = M_LOAD;
            M_LOAD: if (ifc.done_load) begin
               if (m_count < WORDS) m_count++;
               if (m_count == WORDS) begin mode = M_DONE; m_done = 1; end
            end
            M_DONE: mode = M_IDLE;
         endcase
      end
   end

   // ---------------- monitor ----------------
   initial forever begin
      @(negedge clk);
      #3;
      if (resetn) begin
         bit ld, act, rd;
         logic [7:0] eb;
         ld  = (mode == M_LOAD);
         act = ld || (mode == M_ARM);
         rd  = ld && ifc.read_ui_in;
         check("host_ready", ifc.host_ready, act && (sb.size() < 2 || (rd && sb.size() > 0)));
         check("programming", ifc.programming, ld);
         check("bus_oe", ifc.bus_oe, rd);
         if (rd) begin
            if (sb.size() > 0) eb = sb.pop_front();
            else begin eb = 8'h00; und_pend = 1; end
         end else begin
            eb = (ld && sb.size() > 0) ? sb[0] : 8'h00;
         end
         check("bus_out", ifc.bus_out, eb);
         check("load_count", ifc.load_count, m_count);
         check("prog_done", ifc.prog_done, m_done);
         check("underrun", ifc.underrun, m_und);
         check("overflow", ifc.overflow, m_ovf);
      end
   end

   // ---------------- stimulus tasks (enter and leave just after a negedge) ----------------
   task automatic start_session();
      ifc.start = 1; @(negedge clk); ifc.start = 0;
   endtask

   task automatic push_now(input logic [7:0] b);
      ifc.host_valid = 1; ifc.host_data = b; @(negedge clk); ifc.host_valid = 0;
   endtask

   // One sequencer instruction T0..T5; data requested only if programming at T2.
   task automatic seq_instr(input bit t3_push, input logic [7:0] t3_byte);
      bit p;
      ifc.ready = 1; @(negedge clk);
      ifc.ready = 0; @(negedge clk);
      p = ifc.programming; @(negedge clk);
      ifc.read_ui_in = p;
      if (t3_push) begin ifc.host_valid = 1; ifc.host_data = t3_byte; end
      @(negedge clk);
      ifc.read_ui_in = 0; ifc.done_load = p;
      if (t3_push) ifc.host_valid = 0;
      @(negedge clk);
      ifc.done_load = 0; @(negedge clk);
   endtask

   // Well-behaved host: only raises host_valid after seeing room.
   task automatic feeder(input logic [7:0] data[$], input int gap_max,
                         input int stall_after, input int stall_len);
      foreach (data[i]) begin
         bit ok;
         ok = 0;
         if (i == stall_after) repeat (stall_len) @(negedge clk);
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
         for (int t = 0; t < 300 && !ok && !m_done; t++) begin
            #3; ok = ifc.host_ready; @(negedge clk);
         end
         if (ok && !m_done) push_now(data[i]);
      end
   endtask

   task automatic run_stream(input logic [7:0] data[$], input int gap_max,
                             input int stall_after, input int stall_len, input int pre);
      fork
         feeder(data, gap_max, stall_after, stall_len);
         begin
            repeat (pre) @(negedge clk);
            for (int k = 0; k < 40 && !m_done; k++) seq_instr(0, 8'h00);
         end
      join
      check("end_prog_done", ifc.prog_done, 1);
      check("end_load_count", ifc.load_count, WORDS);
      check("end_programming", ifc.programming, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] q[$];
      {ifc.start, ifc.host_valid, ifc.ready, ifc.read_ui_in, ifc.done_load} = '0;
      ifc.host_data = 8'h00;
      {ifc1.start, ifc1.host_valid, ifc1.ready, ifc1.read_ui_in, ifc1.done_load} = '0;
      ifc1.host_data = 8'h00;

      #1 resetn = 0;
      #2;
      check("rst_programming", ifc.programming, 0);
      check("rst_host_ready", ifc.host_ready, 0);
      check("rst_bus_oe", ifc.bus_oe, 0);
      check("rst_bus_out", ifc.bus_out, 0);
      check("rst_load_count", ifc.load_count, 0);
      check("rst_flags", {ifc.prog_done, ifc.underrun, ifc.overflow}, 0);
      @(negedge clk); @(negedge clk);
      resetn = 1;
      @(negedge clk);

      // Host and sequencer noise while idle must be ignored.
      repeat (6) begin
         ifc.host_valid = 1'($urandom_range(0, 1)); ifc.host_data = 8'($urandom);
         ifc.read_ui_in = 1'($urandom_range(0, 1)); ifc.done_load = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      {ifc.host_valid, ifc.read_ui_in, ifc.done_load} = '0;
      @(negedge clk);

      // Normal session, fast host.
      q.delete(); q.push_back(8'h51); q.push_back(8'h2E);
      for (int i = 2; i < WORDS; i++) q.push_back(8'(8'h3F + 8'h13 * (i - 2)));
      start_session();
      run_stream(q, 0, -1, 0, 6);
      check("normal_underrun", ifc.underrun, 0);
      check("normal_overflow", ifc.overflow, 0);
      @(negedge clk);

      // Underrun: host stalls after two bytes.
      q.delete();
      for (int i = 0; i < WORDS; i++) q.push_back(8'($urandom_range(1, 255)));
      start_session();
      run_stream(q, 0, 2, 24, 6);
      check("underrun_set", ifc.underrun, 1);
      @(negedge clk);

      // Overflow: third byte into a full buffer is dropped.
      start_session();
      push_now(8'h11); push_now(8'h22);
      ifc.host_valid = 1; ifc.host_data = 8'hAA;
      #3 check("ovf_host_ready", ifc.host_ready, 0);
      @(negedge clk); ifc.host_valid = 0;
      #3 check("ovf_flag", ifc.overflow, 1);
      @(negedge clk);
      q.delete();
      for (int i = 0; i < WORDS; i++) q.push_back(8'($urandom_range(1, 255)));
      run_stream(q, 0, -1, 0, 0);
      @(negedge clk);

      // Simultaneous push/pop on a full buffer.
      start_session();
      push_now(8'h11); push_now(8'h22);
      seq_instr(1, 8'h33);
      #3 check("simul_overflow", ifc.overflow, 0);
      check("simul_count", ifc.load_count, 1);
      @(negedge clk);
      q.delete();
      for (int i = 0; i < WORDS; i++) q.push_back(8'($urandom_range(1, 255)));
      run_stream(q, 0, -1, 0, 0);
      @(negedge clk);

      // Randomized sessions.
      repeat (3) begin
         q.delete();
         for (int i = 0; i < WORDS + 2; i++) q.push_back(8'($urandom));
         start_session();
         run_stream(q, int'($urandom_range(0, 10)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 6)));
         @(negedge clk);
      end

      // Reset mid-LOAD with one byte buffered.
      start_session();
      push_now(8'h77);
      ifc.ready = 1; @(negedge clk); ifc.ready = 0;
      ifc.read_ui_in = 1;
      #1;
      check("pre_rst_bus_oe", ifc.bus_oe, 1);
      check("pre_rst_bus_out", ifc.bus_out, 8'h77);
      #1 resetn = 0;
      #1;
      check("mid_rst_programming", ifc.programming, 0);
      check("mid_rst_bus_oe", ifc.bus_oe, 0);
      check("mid_rst_load_count", ifc.load_count, 0);
      check("mid_rst_host_ready", ifc.host_ready, 0);
      ifc.read_ui_in = 0;
      @(negedge clk); resetn = 1;
      @(negedge clk);
      #3 check("post_rst_idle", {ifc.programming, ifc.host_ready}, 0);
      @(negedge clk);

      // WORDS=1 instance: start during LOAD ignored, one write ends the session.
      ifc1.start = 1; @(negedge clk); ifc1.start = 0;
      push_1:
      begin
         ifc1.host_valid = 1; ifc1.host_data = 8'h5A; @(negedge clk); ifc1.host_valid = 0;
      end
      ifc1.ready = 1; ifc1.start = 1; @(negedge clk); ifc1.ready = 0;
      #3 check("w1_programming", ifc1.programming, 1);
      @(negedge clk);
      ifc1.read_ui_in = 1;
      #3 check("w1_bus_oe", ifc1.bus_oe, 1);
      check("w1_bus_out", ifc1.bus_out, 8'h5A);
      @(negedge clk);
      ifc1.read_ui_in = 0; ifc1.done_load = 1;
      #3 check("w1_count_pre", ifc1.load_count, 0);
      @(negedge clk);
      ifc1.start = 0;
      #3 check("w1_prog_drop", ifc1.programming, 0);
      check("w1_done", ifc1.prog_done, 1);
      check("w1_count", ifc1.load_count, 1);
      @(negedge clk);
      ifc1.done_load = 0;
      #3 check("w1_idle_count", ifc1.load_count, 1);
      check("w1_idle_done", ifc1.prog_done, 1);
      check("w1_idle_ready", ifc1.host_ready, 0);
      @(negedge clk);
      ifc1.start = 1; @(negedge clk); ifc1.start = 0;
      #3 check("w1_rerun_done_clr", ifc1.prog_done, 0);
      check("w1_rerun_ready", ifc1.host_ready, 1);
      @(negedge clk);
      ifc1.ready = 1; @(negedge clk); ifc1.ready = 0;
      ifc1.read_ui_in = 1;
      #3 check("w1_empty_bus", ifc1.bus_out, 8'h00);
      @(negedge clk);
      ifc1.read_ui_in = 0; ifc1.done_load = 1;
      #3 check("w1_underrun", ifc1.underrun, 1);
      @(negedge clk);
      ifc1.done_load = 0;
      #3 check("w1_rerun_done", ifc1.prog_done, 1);
      check("w1_rerun_count", ifc1.load_count, 1);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
      $fatal(1, "watchdog");
   end
endmodule
